// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a cache that moves whole cachelines to a memory
// that moves fixed-width beats. One line transfer is split into (or assembled
// from) s_line/s_burst beats, with a one-cycle completion pulse to the cache.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = s_line / s_burst;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:5]         r_addr;
  logic [s_line-1:0]   r_wline;
  logic [s_line-1:0]   r_rline;

  logic                w_last;
  logic                w_active;
  logic [4:0]          w_unused_offset;

  // Byte offset within the line never reaches memory; bursts are line-aligned.
  assign w_unused_offset = address_i[4:0];

  assign w_last   = (r_cnt == CNT_W'(BEATS - 1));
  assign w_active = (r_state == RD_BURST) || (r_state == WR_BURST);

  // Control FSM: accepts a request in IDLE, counts beats, pulses completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rline <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Write wins when both requests arrive together.
          if (write_i) begin
            r_addr  <= address_i[31:5];
            r_wline <= line_i;
            r_state <= WR_BURST;
          end else if (read_i) begin
            r_addr  <= address_i[31:5];
            r_state <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            r_rline[r_cnt*s_burst +: s_burst] <= burst_i;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= DONE;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= DONE;
          end
        end
        DONE: begin
          // Requests seen here are dropped; the cache must still hold them next cycle.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state, so nothing combinational
  // from the inputs reaches the pins.
  assign read_o    = (r_state == RD_BURST);
  assign write_o   = (r_state == WR_BURST);
  assign resp_o    = (r_state == DONE);
  assign address_o = w_active ? {r_addr, 5'b0} : 32'h0;
  assign burst_o   = (r_state == WR_BURST) ? r_wline[r_cnt*s_burst +: s_burst] : '0;
  assign line_o    = r_rline;

endmodule
